// File: rtl/debounced_led_counter.sv
// Synchronised, debounced up/down buttons step a bounded counter shown on an LED bank; count moves DEBOUNCE_CYCLES+3 clocks after a clean edge, leds one clock later.
// No backpressure: presses are consumed as they are accepted, and simultaneous up/down events cancel.
module debounced_led_counter #(
    parameter int LED_W           = 10,
    parameter int MAX_COUNT       = 1023,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int WRAP            = 1,
    parameter int BTN_ACTIVE_LOW  = 1,
    localparam int CNT_W          = $clog2(MAX_COUNT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] leds,
    output logic [CNT_W-1:0] count,
    output logic             press,
    output logic             sat
);

    localparam int DC_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);
    localparam logic             IDLE_LVL = (BTN_ACTIVE_LOW != 0);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      pressed;
    logic [1:0]      st;
    logic [1:0]      evt;
    logic [DC_W-1:0] dc [2];

    assign raw     = {btn_down, btn_up};
    assign pressed = (BTN_ACTIVE_LOW != 0) ? ~sync2 : sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= {2{IDLE_LVL}};
            sync2 <= {2{IDLE_LVL}};
            st    <= 2'b00;
            evt   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                dc[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                evt[i] <= 1'b0;
                if (pressed[i] == st[i]) begin
                    dc[i] <= '0;
                end else if (dc[i] == DC_LAST) begin
                    st[i]  <= pressed[i];
                    dc[i]  <= '0;
                    evt[i] <= pressed[i];
                end else begin
                    dc[i] <= dc[i] + DC_W'(1);
                end
            end
        end
    end

    logic step_up;
    logic step_down;

    assign step_up   = evt[0] & ~evt[1];
    assign step_down = evt[1] & ~evt[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            press <= 1'b0;
            sat   <= 1'b0;
        end else begin
            press <= 1'b0;
            sat   <= 1'b0;
            if (step_up) begin
                if (count == CNT_MAX) begin
                    if (WRAP != 0) begin
                        count <= '0;
                        press <= 1'b1;
                    end else begin
                        sat <= 1'b1;
                    end
                end else begin
                    count <= count + CNT_W'(1);
                    press <= 1'b1;
                end
            end else if (step_down) begin
                if (count == '0) begin
                    if (WRAP != 0) begin
                        count <= CNT_MAX;
                        press <= 1'b1;
                    end else begin
                        sat <= 1'b1;
                    end
                end else begin
                    count <= count - CNT_W'(1);
                    press <= 1'b1;
                end
            end
        end
    end

    logic [31:0]      cnt32;
    logic [LED_W-1:0] disp;

    assign cnt32 = 32'(count);

    always_comb begin
        disp = '0;
        case (mode)
            2'd0: begin
                for (int i = 0; i < LED_W; i++) begin
                    disp[i] = cnt32[i];
                end
            end
            2'd1: begin
                for (int i = 0; i < LED_W; i++) begin
                    disp[i] = (cnt32 > 32'(i));
                end
            end
            2'd2: begin
                // All ones flags a count too large to show as a single dot.
                if (cnt32 >= 32'(LED_W)) begin
                    disp = '1;
                end else begin
                    for (int i = 0; i < LED_W; i++) begin
                        disp[i] = (cnt32 == 32'(i));
                    end
                end
            end
            default: disp = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            leds <= '0;
        end else begin
            leds <= disp;
        end
    end

endmodule

// File: tb/tb_debounced_led_counter.sv
// Bench for debounced_led_counter: a wrapping and a saturating instance share stimulus and are checked against a window-based model.
module tb_debounced_led_counter;

    localparam int LW = 4;
    localparam int MX = 12;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b1;
    logic       btn_down = 1'b1;
    logic [1:0] mode = 2'd0;

    logic [LW-1:0] leds_w, leds_s;
    logic [3:0]    cnt_w, cnt_s;
    logic          press_w, press_s, sat_w, sat_s;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    debounced_led_counter #(.LED_W(LW), .MAX_COUNT(MX), .DEBOUNCE_CYCLES(DB),
                            .WRAP(1), .BTN_ACTIVE_LOW(1)) dut_w (
        .clock(clk), .reset(rst), .btn_up(btn_up), .btn_down(btn_down), .mode(mode),
        .leds(leds_w), .count(cnt_w), .press(press_w), .sat(sat_w));

    debounced_led_counter #(.LED_W(LW), .MAX_COUNT(MX), .DEBOUNCE_CYCLES(DB),
                            .WRAP(0), .BTN_ACTIVE_LOW(1)) dut_s (
        .clock(clk), .reset(rst), .btn_up(btn_up), .btn_down(btn_down), .mode(mode),
        .leds(leds_s), .count(cnt_s), .press(press_s), .sat(sat_s));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a button's debounced level flips once the last DB synchronised
    // samples (raw delayed by two clocks) all disagree with it.
    bit h_up [DB+2];
    bit h_dn [DB+2];
    bit st_up, st_dn, ev_up, ev_dn;
    int m_cnt [2];
    bit m_press [2];
    bit m_sat [2];
    logic [LW-1:0] m_leds [2];

    function automatic logic [LW-1:0] disp(input int c, input logic [1:0] md);
        case (md)
            2'd0: return LW'(c % (1 << LW));
            2'd1: return LW'((1 << ((c < LW) ? c : LW)) - 1);
            2'd2: return (c < LW) ? LW'(1 << c) : {LW{1'b1}};
            default: return '0;
        endcase
    endfunction

    function automatic bit window_flips(input bit h [DB+2], input bit st);
        for (int j = 2; j < DB + 2; j++) begin
            if (h[j] == st) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DB + 2; j++) begin
                h_up[j] = 1'b0;
                h_dn[j] = 1'b0;
            end
            st_up = 1'b0; st_dn = 1'b0; ev_up = 1'b0; ev_dn = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0; m_press[k] = 1'b0; m_sat[k] = 1'b0; m_leds[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_leds[k]  = disp(m_cnt[k], mode);
                m_press[k] = 1'b0;
                m_sat[k]   = 1'b0;
                if (ev_up && !ev_dn) begin
                    if (m_cnt[k] < MX) begin m_cnt[k]++; m_press[k] = 1'b1; end
                    else if (k == 0) begin m_cnt[k] = 0; m_press[k] = 1'b1; end
                    else m_sat[k] = 1'b1;
                end else if (ev_dn && !ev_up) begin
                    if (m_cnt[k] > 0) begin m_cnt[k]--; m_press[k] = 1'b1; end
                    else if (k == 0) begin m_cnt[k] = MX; m_press[k] = 1'b1; end
                    else m_sat[k] = 1'b1;
                end
            end
            for (int j = DB + 1; j > 0; j--) begin
                h_up[j] = h_up[j-1];
                h_dn[j] = h_dn[j-1];
            end
            h_up[0] = !btn_up;
            h_dn[0] = !btn_down;
            ev_up = 1'b0;
            ev_dn = 1'b0;
            if (window_flips(h_up, st_up)) begin st_up = !st_up; ev_up = st_up; end
            if (window_flips(h_dn, st_dn)) begin st_dn = !st_dn; ev_dn = st_dn; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc count_w", 32'(cnt_w),   32'(m_cnt[0]));
            check("cyc count_s", 32'(cnt_s),   32'(m_cnt[1]));
            check("cyc leds_w",  32'(leds_w),  32'(m_leds[0]));
            check("cyc leds_s",  32'(leds_s),  32'(m_leds[1]));
            check("cyc press_w", 32'(press_w), 32'(m_press[0]));
            check("cyc press_s", 32'(press_s), 32'(m_press[1]));
            check("cyc sat_w",   32'(sat_w),   32'(m_sat[0]));
            check("cyc sat_s",   32'(sat_s),   32'(m_sat[1]));
        end
    end

    task automatic tap_up();
        @(negedge clk) btn_up = 1'b0;
        repeat (12) @(negedge clk);
        btn_up = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic tap_down();
        @(negedge clk) btn_down = 1'b0;
        repeat (12) @(negedge clk);
        btn_down = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic set_mode_check(input logic [1:0] md, input logic [LW-1:0] exp, input string nm);
        @(negedge clk) mode = md;
        @(posedge clk) #1;
        check({nm, "_w"}, 32'(leds_w), 32'(exp));
        check({nm, "_s"}, 32'(leds_s), 32'(exp));
    endtask

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check("reset count", 32'(cnt_w), 32'd0);
        check("reset leds",  32'(leds_w), 32'd0);
        check("reset press", 32'(press_w), 32'd0);
        check("reset sat",   32'(sat_s), 32'd0);

        @(negedge clk) btn_up = 1'b0;
        repeat (5) @(negedge clk);
        btn_up = 1'b1;
        repeat (15) @(negedge clk);
        check("glitch ignored", 32'(cnt_w), 32'd0);

        @(negedge clk) btn_up = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("latency edge10", 32'(cnt_w), 32'd0);
        @(posedge clk) #1;
        check("latency edge11", 32'(cnt_w), 32'd1);
        check("first press",    32'(press_w), 32'd1);
        repeat (9) @(negedge clk);
        btn_up = 1'b1;
        repeat (12) @(negedge clk);
        check("mode0 count1", 32'(leds_w), 32'b0001);

        repeat (2) tap_up();
        set_mode_check(2'd1, 4'b0111, "bar3");
        set_mode_check(2'd2, 4'b1000, "dot3");
        set_mode_check(2'd3, 4'b0000, "blank3");
        @(negedge clk) mode = 2'd0;
        repeat (3) tap_up();
        set_mode_check(2'd1, 4'b1111, "bar6");
        set_mode_check(2'd2, 4'b1111, "dot6");
        set_mode_check(2'd0, 4'b0110, "bin6");

        @(negedge clk) begin btn_up = 1'b0; btn_down = 1'b0; end
        repeat (11) @(posedge clk);
        #1 check("both press", 32'(press_w), 32'd0);
        check("both count", 32'(cnt_w), 32'd6);
        repeat (2) @(negedge clk);
        btn_up = 1'b1; btn_down = 1'b1;
        repeat (12) @(negedge clk);

        repeat (6) tap_up();
        check("count12 w", 32'(cnt_w), 32'd12);
        @(negedge clk) btn_up = 1'b0;
        repeat (11) @(posedge clk);
        #1 check("wrap to 0", 32'(cnt_w), 32'd0);
        check("wrap press", 32'(press_w), 32'd1);
        check("sat hold",   32'(cnt_s), 32'd12);
        check("sat pulse",  32'(sat_s), 32'd1);
        check("sat nopress", 32'(press_s), 32'd0);
        repeat (2) @(negedge clk);
        btn_up = 1'b1;
        repeat (12) @(negedge clk);

        tap_down();
        check("down wrap", 32'(cnt_w), 32'd12);
        check("down sat inst", 32'(cnt_s), 32'd11);

        @(negedge clk) btn_down = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mid reset count", 32'(cnt_w), 32'd0);
        repeat (10) @(posedge clk);
        #1 check("held edge10", 32'(cnt_w), 32'd0);
        @(posedge clk) #1;
        check("held down w",   32'(cnt_w), 32'd12);
        check("held down s",   32'(cnt_s), 32'd0);
        check("held sat s",    32'(sat_s), 32'd1);
        repeat (6) @(negedge clk);
        btn_down = 1'b1;
        repeat (15) @(negedge clk);
        check("one press only", 32'(cnt_w), 32'd12);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
